// File: rtl/logic_e_pkg.sv
// Shared types and constants for the serially configured logic element.
package logic_e_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    FN_AND  = 3'd0,
    FN_OR   = 3'd1,
    FN_NOT  = 3'd2,
    FN_XOR  = 3'd3,
    FN_XNOR = 3'd4,
    FN_NAND = 3'd5,
    FN_NOR  = 3'd6,
    FN_BUF  = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    SHIFTING = 2'd1,
    FULL     = 2'd2
  } cfg_state_e;

  function automatic int cfg_width(input int sel_w);
    return FUNC_W + 2 * sel_w;
  endfunction

endpackage

// File: rtl/logic_e_cfg_chain.sv
// Bit-serial configuration shadow register with fill tracking; the shadow MSB
// doubles as scan-out so elements can be daisy-chained.
module logic_e_cfg_chain
  import logic_e_pkg::*;
#(
  parameter int CFG_W = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_en_i,
  input  logic             cfg_sdi_i,
  input  logic             cfg_load_i,
  output logic             cfg_sdo_o,
  output logic             cfg_full_o,
  output logic             cfg_err_o,
  output logic             commit_o,
  output logic [CFG_W-1:0] shadow_o
);

  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic             err_q, err_d;
  logic             commit_s;

  // Next-state: shift, fill counter and commit/error decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    commit_s = 1'b0;
    if (cfg_en_i) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_sdi_i};
    end else begin
      shadow_d = shadow_q;
    end
    case (state_q)
      EMPTY: begin
        err_d = cfg_load_i;
        if (cfg_en_i) begin
          state_d = SHIFTING;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      end
      SHIFTING: begin
        err_d = cfg_load_i;
        if (cfg_en_i && (cnt_q == CNT_FULL - CNT_ONE)) begin
          state_d = FULL;
          cnt_d   = CNT_FULL;
        end else if (cfg_en_i) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      FULL: begin
        // A commit always takes the pre-shift shadow; a coincident shift starts the next word
        commit_s = cfg_load_i;
        if (cfg_load_i && cfg_en_i) begin
          state_d = SHIFTING;
          cnt_d   = CNT_ONE;
        end else if (cfg_load_i) begin
          state_d = EMPTY;
          cnt_d   = '0;
        end else begin
          state_d = FULL;
          cnt_d   = CNT_FULL;
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // Configuration chain state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign cfg_sdo_o  = shadow_q[CFG_W-1];
  assign cfg_full_o = (state_q == FULL);
  assign cfg_err_o  = err_q;
  assign commit_o   = commit_s;
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/logic_e_serial.sv
// Evolvable logic element: two selected operands through one of eight functions.
// Define LE_OUT_REG_EN to register le_out (one cycle of latency, resets to 0).
module logic_e_serial
  import logic_e_pkg::*;
#(
  parameter  int NUM_IN = 33,
  parameter  int SEL_W  = 6,
  parameter  int FUNC_W = 3,
  localparam int CFG_W  = cfg_width(SEL_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_sdi,
  output logic              cfg_sdo,
  input  logic              cfg_load,
  output logic              cfg_full,
  output logic              cfg_err,
  output logic [CFG_W-1:0]  cfg_active,
  input  logic [NUM_IN-1:0] all_inputs,
  output logic              le_out
);

  logic [CFG_W-1:0]      active_q, active_d, shadow_s;
  logic                  commit_s;
  logic [2**SEL_W-1:0]   in_pad_s;
  logic [SEL_W-1:0]      sel_a_s, sel_b_s;
  func_e                 func_s;
  logic                  op_a_s, op_b_s, le_s;

  logic_e_cfg_chain #(.CFG_W(CFG_W)) u_chain (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_en_i   (cfg_en),
    .cfg_sdi_i  (cfg_sdi),
    .cfg_load_i (cfg_load),
    .cfg_sdo_o  (cfg_sdo),
    .cfg_full_o (cfg_full),
    .cfg_err_o  (cfg_err),
    .commit_o   (commit_s),
    .shadow_o   (shadow_s)
  );

  // Active configuration update on commit
  always_comb begin
    if (commit_s) begin
      active_d = shadow_s;
    end else begin
      active_d = active_q;
    end
  end

  // Active configuration register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  // Operand selection and function evaluation; zero padding makes out-of-range selects read 0
  always_comb begin
    in_pad_s               = '0;
    in_pad_s[NUM_IN-1:0]   = all_inputs;
    sel_a_s                = active_q[SEL_W-1:0];
    sel_b_s                = active_q[2*SEL_W-1:SEL_W];
    func_s                 = func_e'(active_q[CFG_W-1 -: FUNC_W]);
    op_a_s                 = in_pad_s[sel_a_s];
    op_b_s                 = in_pad_s[sel_b_s];
    case (func_s)
      FN_AND:  le_s = op_a_s & op_b_s;
      FN_OR:   le_s = op_a_s | op_b_s;
      FN_NOT:  le_s = ~op_a_s;
      FN_XOR:  le_s = op_a_s ^ op_b_s;
      FN_XNOR: le_s = ~(op_a_s ^ op_b_s);
      FN_NAND: le_s = ~(op_a_s & op_b_s);
      FN_NOR:  le_s = ~(op_a_s | op_b_s);
      FN_BUF:  le_s = op_a_s;
      default: le_s = 1'b0;
    endcase
  end

`ifdef LE_OUT_REG_EN
  logic le_q;

  // Registered element output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      le_q <= 1'b0;
    end else begin
      le_q <= le_s;
    end
  end

  assign le_out = le_q;
`else
  assign le_out = le_s;
`endif

  assign cfg_active = active_q;

endmodule

// File: tb/tb_logic_e_serial.sv
// Self-checking bench for logic_e_serial: directed table, corner sequences and
// randomized traffic against a truth-table reference model.
module tb_logic_e_serial;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic        cfg_sdi;
  logic        cfg_sdo;
  logic        cfg_load;
  logic        cfg_full;
  logic        cfg_err;
  logic [14:0] cfg_active;
  logic [32:0] all_inputs;
  logic        le_out;

  logic_e_serial #(.NUM_IN(33), .SEL_W(6), .FUNC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_sdi    (cfg_sdi),
    .cfg_sdo    (cfg_sdo),
    .cfg_load   (cfg_load),
    .cfg_full   (cfg_full),
    .cfg_err    (cfg_err),
    .cfg_active (cfg_active),
    .all_inputs (all_inputs),
    .le_out     (le_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_cnt;
  logic [14:0] m_sh;
  logic [14:0] m_act;
  logic        m_err;
  logic        m_le_q;

  typedef struct {
    logic [14:0] word;
    logic [32:0] ins;
    logic        exp_le;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-function truth tables, nibble index = {a,b}; AND in the low nibble.
  function automatic logic ref_le(input logic [14:0] word, input logic [32:0] ins);
    logic [31:0] luts;
    int f, sa, sb, a, b;
    luts = {4'b1100, 4'b0001, 4'b0111, 4'b1001, 4'b0110, 4'b0011, 4'b1110, 4'b1000};
    f  = int'(word[14:12]);
    sb = int'(word[11:6]);
    sa = int'(word[5:0]);
    a  = (sa < 33) ? int'(ins[sa]) : 0;
    b  = (sb < 33) ? int'(ins[sb]) : 0;
    return luts[f*4 + a*2 + b];
  endfunction

  function automatic logic exp_le_now();
`ifdef LE_OUT_REG_EN
    return m_le_q;
`else
    return ref_le(m_act, all_inputs);
`endif
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_sh   = '0;
    m_act  = '0;
    m_err  = 1'b0;
    m_le_q = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic sdi, input logic load, input logic [32:0] ins);
    bit full_pre;
    bit commit;
    full_pre = (m_cnt >= 15);
    commit   = load && full_pre;
    m_err    = load && !full_pre;
    m_le_q   = ref_le(m_act, ins);
    if (commit) m_act = m_sh;
    if (en) m_sh = {m_sh[13:0], sdi};
    if (commit) m_cnt = en ? 1 : 0;
    else if (en) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
  endtask

  task automatic cycle(input logic en, input logic sdi, input logic load, input logic [32:0] ins);
    cfg_en     = en;
    cfg_sdi    = sdi;
    cfg_load   = load;
    all_inputs = ins;
    #1;
    chk("le_out_comb", le_out, exp_le_now());
    @(posedge clk);
    model_edge(en, sdi, load, ins);
    #1;
    chk("cfg_sdo", cfg_sdo, m_sh[14]);
    chk("cfg_full", cfg_full, (m_cnt >= 15));
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_active", cfg_active, m_act);
    chk("le_out", le_out, exp_le_now());
  endtask

  task automatic shift_word(input logic [14:0] w, input logic [32:0] ins);
    for (int i = 14; i >= 0; i--) cycle(1'b1, w[i], 1'b0, ins);
  endtask

  task automatic load_word(input logic [14:0] w, input logic [32:0] ins);
    shift_word(w, ins);
    cycle(1'b0, 1'b0, 1'b1, ins);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] w;
    logic        exp_rst_le;
`ifdef LE_OUT_REG_EN
    exp_rst_le = 1'b0;
`else
    exp_rst_le = 1'b1;
`endif
    vt[0]  = '{15'h3143, 33'h0_0000_0008, 1'b1};
    vt[1]  = '{15'h3143, 33'h0_0000_0028, 1'b0};
    vt[2]  = '{15'h7028, 33'h1_FFFF_FFFF, 1'b0};
    vt[3]  = '{15'h7028, 33'h0_0000_0000, 1'b0};
    vt[4]  = '{15'h0042, 33'h0_0000_0006, 1'b1};
    vt[5]  = '{15'h0042, 33'h0_0000_0002, 1'b0};
    vt[6]  = '{15'h6800, 33'h0_0000_0000, 1'b1};
    vt[7]  = '{15'h6800, 33'h1_0000_0000, 1'b0};
    vt[8]  = '{15'h5FCA, 33'h1_FFFF_FFFF, 1'b1};
    vt[9]  = '{15'h2020, 33'h1_0000_0000, 1'b0};
    vt[10] = '{15'h2020, 33'h0_0000_0000, 1'b1};
    vt[11] = '{15'h1207, 33'h0_0000_0100, 1'b1};
    vt[12] = '{15'h1207, 33'h0_0000_0000, 1'b0};
    vt[13] = '{15'h4000, 33'h1_2345_6789, 1'b1};

    rst        = 1'b1;
    cfg_en     = 1'b0;
    cfg_sdi    = 1'b0;
    cfg_load   = 1'b0;
    all_inputs = 33'h0_0000_0001;
    #3;
    chk("rst_le_out", le_out, exp_rst_le);
    chk("rst_sdo", cfg_sdo, 1'b0);
    chk("rst_full", cfg_full, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_active", cfg_active, 15'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 33'h0_0000_0001);
    chk("rst_and_in0", le_out, 1'b1);

    // XOR word: cfg_full must rise only after the 15th shift
    w = 15'h3143;
    for (int i = 14; i >= 0; i--) begin
      cycle(1'b1, w[i], 1'b0, 33'h0);
      chk("full_rise", cfg_full, (i == 0));
    end
    cycle(1'b0, 1'b0, 1'b1, 33'h0_0000_0008);
    chk("commit_3143", cfg_active, 15'h3143);
    cycle(1'b0, 1'b0, 1'b0, 33'h0_0000_0008);
    chk("xor_a1_b0", le_out, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 33'h0_0000_0028);
    chk("xor_a1_b1", le_out, 1'b0);

    // Premature load after 7 bits
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 33'h0);
    cycle(1'b0, 1'b0, 1'b1, 33'h0);
    chk("early_err_hi", cfg_err, 1'b1);
    chk("early_active", cfg_active, 15'h3143);
    chk("early_full", cfg_full, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 33'h0);
    chk("early_err_lo", cfg_err, 1'b0);
    for (int k = 8; k <= 15; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 33'h0);
      chk("early_cnt7", cfg_full, (k == 15));
    end

    // Commit and shift in the same cycle while full
    w = 15'h2B6D;
    shift_word(w, 33'h0);
    cycle(1'b1, 1'b1, 1'b1, 33'h0);
    chk("dual_active", cfg_active, 15'h2B6D);
    chk("dual_full", cfg_full, 1'b0);
    chk("dual_sdo", cfg_sdo, w[13]);
    for (int k = 1; k <= 14; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 33'h0);
      chk("dual_cnt1", cfg_full, (k == 14));
      if (k <= 13) chk("dual_replay", cfg_sdo, w[13-k]);
    end

    // Table of configurations
    for (int i = 0; i < 14; i++) begin
      load_word(vt[i].word, vt[i].ins);
      cycle(1'b0, 1'b0, 1'b0, vt[i].ins);
      chk("tbl_active", cfg_active, vt[i].word);
      chk("tbl_le_out", le_out, vt[i].exp_le);
    end

    // Asynchronous reset at bit 9 of a shift
    for (int i = 0; i < 9; i++) cycle(1'b1, i[0], 1'b0, 33'h1_FFFF_FFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sdo", cfg_sdo, 1'b0);
    chk("arst_full", cfg_full, 1'b0);
    chk("arst_err", cfg_err, 1'b0);
    chk("arst_active", cfg_active, 15'h0000);
    chk("arst_le_out", le_out, exp_rst_le);
    model_reset();
    #1;
    rst = 1'b0;
    load_word(15'h3143, 33'h0_0000_0008);
    cycle(1'b0, 1'b0, 1'b0, 33'h0_0000_0008);
    chk("arst_reload", cfg_active, 15'h3143);
    chk("arst_reload_le", le_out, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), {1'($urandom_range(0, 1)), 32'($urandom)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
